// File: rtl/reg_scoreboard.sv
// reg_scoreboard: RAW/overflow hazard scoreboard between decode and regfile read,
// counting in-flight writes per GPR and for the predicate/status bit.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic              dec_use_ra,
  input  logic              dec_use_rt,
  input  logic [ADDR_W-1:0] dec_rt_addr,
  input  logic              dec_read_ps,
  input  logic              dec_reg_write,
  input  logic [ADDR_W-1:0] dec_reg_addr,
  input  logic              dec_ps_write,
  input  logic              ex_ready,
  output logic              reg_read_valid,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_reg_addr,
  input  logic              wb_ps_write,
  input  logic              flush,
  output logic              idle,
  output logic              underflow_err,
  output logic [15:0]       stall_cycles
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic [CNT_W-1:0] w_cnt_nxt [NUM_REGS];
  logic [CNT_W-1:0] r_ps_cnt, w_ps_nxt;
  logic             r_underflow;
  logic [15:0]      r_stall;
  logic             w_hazard, w_issue, w_inc, w_dec, w_uf, w_idle;

  function automatic logic [CNT_W-1:0] step(input logic [CNT_W-1:0] c, input logic inc, input logic dec);
    return (inc && !dec) ? c + CNT_W'(1) : (dec && !inc && c != '0) ? c - CNT_W'(1) : c;
  endfunction

  // Hazards look only at registered counts: a same-cycle retire lands at the edge.
  always_comb begin
    w_hazard = (dec_use_ra && r_cnt[0] != '0) ||
               (dec_use_rt && r_cnt[dec_rt_addr] != '0) ||
               (dec_read_ps && r_ps_cnt != '0) ||
               (dec_reg_write && r_cnt[dec_reg_addr] == MAX) ||
               (dec_ps_write && r_ps_cnt == MAX);
  end

  assign dec_ready      = !w_hazard && ex_ready && !flush;
  assign w_issue        = dec_valid && dec_ready;
  assign reg_read_valid = w_issue;

  always_comb begin
    w_idle = (r_ps_cnt == '0);
    w_uf   = 1'b0;
    w_inc  = 1'b0;
    w_dec  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_inc        = w_issue && dec_reg_write && dec_reg_addr == ADDR_W'(i);
      w_dec        = wb_valid && wb_reg_write && wb_reg_addr == ADDR_W'(i);
      w_idle       = w_idle && (r_cnt[i] == '0);
      w_uf         = w_uf || (!flush && w_dec && r_cnt[i] == '0);
      w_cnt_nxt[i] = flush ? '0 : step(r_cnt[i], w_inc, w_dec);
    end
    w_inc    = w_issue && dec_ps_write;
    w_dec    = wb_valid && wb_ps_write;
    w_uf     = w_uf || (!flush && w_dec && r_ps_cnt == '0);
    w_ps_nxt = flush ? '0 : step(r_ps_cnt, w_inc, w_dec);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
      r_ps_cnt    <= '0;
      r_underflow <= 1'b0;
      r_stall     <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_ps_cnt    <= w_ps_nxt;
      r_underflow <= r_underflow || w_uf;
      if (dec_valid && !dec_ready && !flush && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
    end
  end

  assign idle          = w_idle;
  assign underflow_err = r_underflow;
  assign stall_cycles  = r_stall;
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Hazard scoreboard sitting between the decoder and the register file read port.
- Tracks outstanding writes to each GPR and to the predicate/status bit (ps).
- Stalls decode on read-after-write and counter-overflow hazards.
- Drives reg_read_valid into the regfile and releases entries when the writeback stage retires.
- No forwarding: a consumer issues only once the producer's regfile write has landed.

Parameters:
- NUM_REGS, 16, number of GPRs tracked; reg 0 is the accumulator ra.
- ADDR_W, 4, GPR address width; NUM_REGS equals 2**ADDR_W.
- CNT_W, 2, width of each pending-write counter; max in-flight writes per target is 2**CNT_W-1.

Ports:
- clk  in  1  clock.
- n_rst  in  1  synchronous active-low reset.
- dec_valid  in  1  decoder presents an instruction.
- dec_ready  out  1  scoreboard accepts the instruction this cycle.
- dec_use_ra  in  1  instruction reads regs[0].
- dec_use_rt  in  1  instruction reads regs[dec_rt_addr].
- dec_rt_addr  in  ADDR_W  rt source address.
- dec_read_ps  in  1  instruction reads ps.
- dec_reg_write  in  1  instruction will write a GPR.
- dec_reg_addr  in  ADDR_W  destination GPR.
- dec_ps_write  in  1  instruction will write ps.
- ex_ready  in  1  downstream stage can accept an instruction.
- reg_read_valid  out  1  issue strobe to regfile and execute stage.
- wb_valid  in  1  writeback retiring an instruction.
- wb_reg_write  in  1  retiring instruction writes a GPR.
- wb_reg_addr  in  ADDR_W  retiring destination.
- wb_ps_write  in  1  retiring instruction writes ps.
- flush  in  1  squash all in-flight, unretired instructions.
- idle  out  1  no outstanding writes anywhere.
- underflow_err  out  1  sticky: retire seen with a zero counter.
- stall_cycles  out  16  saturating count of cycles with dec_valid high and dec_ready low.

Behaviour:
- State:
  - cnt[NUM_REGS], each CNT_W bits.
  - ps_cnt, CNT_W bits.
  - underflow_err flag.
  - stall_cycles counter.
- Reset (n_rst low at posedge):
  - all cnt and ps_cnt = 0.
  - underflow_err = 0.
  - stall_cycles = 0.
- Resulting outputs during and after reset: idle=1, dec_ready=ex_ready, reg_read_valid=0 unless an issue fires.
- hazard (combinational, registered counters only; same-cycle retire is never considered because the regfile write lands at the edge):
  - dec_use_ra && cnt[0]!=0
  - OR dec_use_rt && cnt[dec_rt_addr]!=0
  - OR dec_read_ps && ps_cnt!=0
  - OR dec_reg_write && cnt[dec_reg_addr]==MAX
  - OR dec_ps_write && ps_cnt==MAX
- Handshake:
  - dec_ready = !hazard && ex_ready && !flush.
  - issue = dec_valid && dec_ready.
  - reg_read_valid = issue, combinational, zero latency.
- Counter update at posedge, for each target:
  - +1 if issue writes it; -1 if wb_valid retires a write to it.
  - Both in the same cycle: counter unchanged.
  - dec_reg_write and dec_ps_write may both be set: each counter updates independently.
- Underflow: a retire to a target whose counter is 0 leaves the counter at 0 and sets underflow_err. underflow_err clears only on reset.
- Flush:
  - All cnt and ps_cnt cleared to 0 at the next edge.
  - A wb_valid in the flush cycle is ignored, with no underflow check.
  - dec_ready is forced 0 in the flush cycle.
  - underflow_err and stall_cycles are preserved.
- idle = all counters zero (registered state).
- stall_cycles increments when dec_valid && !dec_ready && !flush, and saturates at 0xFFFF.
- dec_* fields are don't-care when dec_valid=0.
- wb_* fields are don't-care when wb_valid=0.

Test Plan:
- Reset, then issue "write r3" then "read rt=r3" on consecutive cycles:
  - second instruction has dec_ready=0 until the cycle after wb retires r3.
  - stall_cycles equals the stall count.
  - cnt[3] goes 0→1→0.
- Issue "write r0" and retire r0 in the same cycle with cnt[0]=1:
  - cnt[0] stays 1.
  - a following use_ra instruction still stalls.
- Three back-to-back writes to r5 with no retire (CNT_W=2):
  - all three accepted.
  - fourth write to r5 stalls with cnt[5]=3.
  - one retire brings cnt[5] to 2 and releases the stall.
- ps_write issued, read_ps pending:
  - stalls while ps_cnt=1.
  - ex_ready=0 alone also holds dec_ready=0 with no counter change.
- Retire r7 with cnt[7]=0:
  - underflow_err=1 and stays 1 after a later flush.
  - cnt[7] stays 0.
- Pending writes on r1, r2 and ps, then assert flush with dec_valid=1:
  - no issue that cycle.
  - next cycle idle=1 and the pending reader issues immediately.
